pc_unit: RTL and testbench

Parametrised program-counter unit for the pipelined MIPS core; it is the next generation of the single-cycle PC register. It holds the fetch address and selects the next PC from reset vector, exception vector, ERET return address, branch/jump redirect or sequential PC+4. It adds stall support, a one-entry buffer for redirects that arrive during a stall, and fetch-fault detection. It sits at the head of IF, feeding instruction memory and the IF/ID register.

---
 rtl/pc_unit.sv | 88 ++++++++
 tb/tb_pc_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter for the pipelined MIPS core: holds the fetch address and picks the next PC
// from reset, exception, ERET, redirect (live or buffered during a stall) or pc+4.
// One cycle from any qualifying input to the new pc. A redirect seen during a stall is buffered.
module pc_unit #(
  parameter int                 WIDTH        = 32,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0]   EXC_VECTOR   = WIDTH'(32'h0000_4180),
  parameter logic [WIDTH-1:0]   IMEM_BASE    = WIDTH'(32'h0000_3000),
  parameter int unsigned        IMEM_BYTES   = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             redir_pending,
  output logic             fetch_fault
);

  // The window end gets one extra bit so that base + size never wraps.
  localparam logic [WIDTH:0] WIN_END = {1'b0, IMEM_BASE} + (WIDTH+1)'(IMEM_BYTES);

  // RUN: nothing buffered. HOLD: pend_target holds a redirect that arrived during a stall.
  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] pc_nx;
  logic [WIDTH-1:0] pend_target;
  logic [WIDTH-1:0] pend_nx;
  logic             below_base;
  logic             above_end;

  assign pc_plus4      = pc + WIDTH'(4);
  assign redir_pending = (state == HOLD);

  // A leading 1 on both operands keeps the ordering unchanged, and the compare still works when the base is zero.
  assign below_base  = {1'b1, pc} < {1'b1, IMEM_BASE};
  assign above_end   = {1'b0, pc} >= WIN_END;
  assign fetch_fault = (pc[1:0] != 2'b00) || below_base || above_end;

  // State register. Reset has the highest priority and clears the buffered target.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_VECTOR;
      state       <= RUN;
      pend_target <= '0;
    end else begin
      pc          <= pc_nx;
      state       <= state_nx;
      pend_target <= pend_nx;
    end
  end

  // Next-PC selection. Exception and ERET override a stall. A buffered redirect is older than a live one.
  always_comb begin
    pc_nx    = pc_plus4;
    state_nx = state;
    pend_nx  = pend_target;
    if (exc_req) begin
      pc_nx    = EXC_VECTOR;
      state_nx = RUN;
    end else if (eret) begin
      pc_nx    = epc;
      state_nx = RUN;
    end else if (stall) begin
      pc_nx = pc;
      if (redir_valid) begin
        pend_nx  = redir_target;
        state_nx = HOLD;
      end
    end else if (state == HOLD) begin
      pc_nx    = pend_target;
      state_nx = RUN;
    end else if (redir_valid) begin
      pc_nx = redir_target;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed test-plan steps, then a randomized run against a reference model.
// Covers the default 32-bit instance and a 16-bit instance with a full-range window to check wrap.
// Inputs change 1 time unit after the rising edge. Outputs are sampled 1 time unit after the edge.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, redir_valid, exc_req, eret;
  logic [31:0] redir_target, epc;
  logic [31:0] pc, pc_plus4;
  logic        redir_pending, fetch_fault;

  logic        r16, s16, rv16, ex16, er16;
  logic [15:0] rt16, ep16;
  logic [15:0] pc16, pc16_plus4;
  logic        pend16, fault16;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: the architectural PC, plus an optional buffered redirect.
  logic [31:0] m_pc;
  bit          m_has_pend;
  logic [31:0] m_pend;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redir_valid(redir_valid),
    .redir_target(redir_target), .exc_req(exc_req), .eret(eret), .epc(epc),
    .pc(pc), .pc_plus4(pc_plus4), .redir_pending(redir_pending), .fetch_fault(fetch_fault)
  );

  pc_unit #(
    .WIDTH(16), .RESET_VECTOR(16'h0000), .EXC_VECTOR(16'h4180),
    .IMEM_BASE(16'h0000), .IMEM_BYTES(65536)
  ) u16 (
    .clk(clk), .reset(r16), .stall(s16), .redir_valid(rv16),
    .redir_target(rt16), .exc_req(ex16), .eret(er16), .epc(ep16),
    .pc(pc16), .pc_plus4(pc16_plus4), .redir_pending(pend16), .fetch_fault(fault16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a >= 32'h3000 + 4096);
  endfunction

  // Applies one clock edge to the model, following the priority list from the top.
  task automatic model_edge(input bit r, s, rv, input logic [31:0] rt, input bit ex, er, input logic [31:0] ep);
    if (r) begin
      m_pc = 32'h3000; m_has_pend = 0; m_pend = 0;
    end else if (ex) begin
      m_pc = 32'h4180; m_has_pend = 0;
    end else if (er) begin
      m_pc = ep; m_has_pend = 0;
    end else if (s) begin
      if (rv) begin m_pend = rt; m_has_pend = 1; end
    end else if (m_has_pend) begin
      m_pc = m_pend; m_has_pend = 0;
    end else if (rv) begin
      m_pc = rt;
    end else begin
      m_pc = m_pc + 4;
    end
  endtask

  // Drives one cycle of inputs, clocks the DUT, updates the model, then compares every output.
  task automatic step(input string tag, input bit r, s, rv, input logic [31:0] rt,
                      input bit ex, er, input logic [31:0] ep);
    reset = r; stall = s; redir_valid = rv; redir_target = rt; exc_req = ex; eret = er; epc = ep;
    @(posedge clk);
    model_edge(r, s, rv, rt, ex, er, ep);
    #1;
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
    chk({tag, ".pending"}, 32'(redir_pending), 32'(m_has_pend));
    chk({tag, ".fault"}, 32'(fetch_fault), 32'(model_fault(m_pc)));
  endtask

  task automatic step16(input bit r, rv, input logic [15:0] rt);
    r16 = r; s16 = 0; rv16 = rv; rt16 = rt; ex16 = 0; er16 = 0; ep16 = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_pc = 0; m_has_pend = 0; m_pend = 0;
    reset = 1; stall = 0; redir_valid = 0; redir_target = 0; exc_req = 0; eret = 0; epc = 0;
    r16 = 1; s16 = 0; rv16 = 0; rt16 = 0; ex16 = 0; er16 = 0; ep16 = 0;
    #1;

    // Reset followed by sequential fetch.
    step("reset", 1, 0, 0, 0, 0, 0, 0);
    chk("reset_pc", pc, 32'h3000);
    chk("reset_pending", 32'(redir_pending), 32'd0);
    step("seq1", 0, 0, 0, 0, 0, 0, 0);
    step("seq2", 0, 0, 0, 0, 0, 0, 0);
    chk("seq_pc_3008", pc, 32'h3008);
    step("seq3", 0, 0, 0, 0, 0, 0, 0);
    chk("seq_pc_300c", pc, 32'h300C);

    // Live redirect.
    step("redir", 0, 0, 1, 32'h3100, 0, 0, 0);
    chk("redir_pc", pc, 32'h3100);
    step("redir_seq", 0, 0, 0, 0, 0, 0, 0);
    chk("redir_next", pc, 32'h3104);

    // Stall with a buffered redirect; the live redirect at release is ignored.
    step("to3010", 0, 0, 1, 32'h3010, 0, 0, 0);
    step("stall1", 0, 1, 1, 32'h3200, 0, 0, 0);
    chk("stall1_pc", pc, 32'h3010);
    chk("stall1_pending", 32'(redir_pending), 32'd1);
    step("stall2", 0, 1, 0, 0, 0, 0, 0);
    step("stall3", 0, 1, 0, 0, 0, 0, 0);
    chk("stall3_pc", pc, 32'h3010);
    step("release", 0, 0, 1, 32'h3300, 0, 0, 0);
    chk("release_pc", pc, 32'h3200);
    chk("release_pending", 32'(redir_pending), 32'd0);

    // An exception, also with eret high, pre-empts HOLD even while stalled.
    step("hold", 0, 1, 1, 32'h3200, 0, 0, 0);
    step("exc", 0, 1, 0, 0, 1, 1, 32'h3024);
    chk("exc_pc", pc, 32'h4180);
    chk("exc_pending", 32'(redir_pending), 32'd0);

    // ERET to an aligned return address, then to a misaligned one.
    step("eret", 0, 0, 0, 0, 0, 1, 32'h3024);
    chk("eret_pc", pc, 32'h3024);
    step("eret_mis", 0, 0, 0, 0, 0, 1, 32'h3026);
    chk("eret_mis_pc", pc, 32'h3026);
    chk("eret_mis_fault", 32'(fetch_fault), 32'd1);

    // Window end: one past the last legal byte faults, the last legal word does not.
    step("win_end", 0, 0, 1, 32'h4000, 0, 0, 0);
    chk("win_end_fault", 32'(fetch_fault), 32'd1);
    step("win_last", 0, 0, 1, 32'h3FFC, 0, 0, 0);
    chk("win_last_fault", 32'(fetch_fault), 32'd0);
    step("win_below", 0, 0, 1, 32'h2FFC, 0, 0, 0);
    chk("win_below_fault", 32'(fetch_fault), 32'd1);

    // Reset while in HOLD drops the pending target.
    step("hold2", 0, 1, 1, 32'h3500, 0, 0, 0);
    step("reset_hold", 1, 1, 0, 0, 0, 0, 0);
    chk("reset_hold_pc", pc, 32'h3000);
    chk("reset_hold_pending", 32'(redir_pending), 32'd0);

    // Randomized run checked against the model.
    for (int i = 0; i < 600; i++) begin
      bit          r, s, rv, ex, er;
      logic [31:0] rt, ep;
      r  = ($urandom_range(0, 59) == 0);
      s  = ($urandom_range(0, 2) == 0);
      rv = ($urandom_range(0, 3) == 0);
      ex = ($urandom_range(0, 24) == 0);
      er = ($urandom_range(0, 24) == 0);
      rt = ($urandom_range(0, 7) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 1023)) * 4;
      ep = ($urandom_range(0, 7) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 1023)) * 4;
      step("rand", r, s, rv, rt, ex, er, ep);
    end

    // 16-bit instance: a full 64 KiB window, so the PC wraps from 0xFFFC to 0x0000.
    step16(1, 0, 16'h0);
    chk("w16_reset_pc", 32'(pc16), 32'h0);
    step16(0, 1, 16'hFFFC);
    chk("w16_fffc_pc", 32'(pc16), 32'hFFFC);
    chk("w16_fffc_plus4", 32'(pc16_plus4), 32'h0);
    chk("w16_fffc_fault", 32'(fault16), 32'd0);
    step16(0, 0, 16'h0);
    chk("w16_wrap_pc", 32'(pc16), 32'h0);
    chk("w16_wrap_fault", 32'(fault16), 32'd0);
    chk("w16_pending", 32'(pend16), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
